// File: rtl/lcd_ctrl.sv
// HD44780 16x2 LCD write sequencer: power-up wait, fixed init list, then valid/ready byte writes.
// Optional LCD_LINE_WRAP_EN adds a cursor tracker that inserts set-DDRAM commands on line wrap.
module lcd_ctrl #(
  parameter int unsigned PWR_CYC  = 750000,
  parameter int unsigned SU_CYC   = 2,
  parameter int unsigned E_CYC    = 25,
  parameter int unsigned HD_CYC   = 2,
  parameter int unsigned EXEC_CYC = 2000,
  parameter int unsigned CLR_CYC  = 82000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       req_ready_o,
  output logic       init_done_o,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic [7:0] data_lcd
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(PWR_CYC, SU_CYC), max2(E_CYC, HD_CYC)),
                                         max2(EXEC_CYC, CLR_CYC));
  localparam int unsigned TW = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, SETUP, E_HIGH, HOLD, EXEC, IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    init_idx_q, init_idx_d;
  logic          init_done_q, init_done_d;
  logic          ready_q, ready_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          rw_q, on_q, blon_q;
  logic          tmr_zero_c;
  logic          is_clr_c;
  logic [7:0]    init_byte_c;

`ifdef LCD_LINE_WRAP_EN
  logic [3:0] col_q, col_d;
  logic       line_q, line_d;
  logic       pend_q, pend_d;
  logic       load_c;
  logic       ins_c;
`endif

  assign tmr_zero_c = (tmr_q == '0);
  assign is_clr_c   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

  always_comb begin
    unique case (init_idx_q)
      2'd0:    init_byte_c = 8'h38;
      2'd1:    init_byte_c = 8'h0C;
      2'd2:    init_byte_c = 8'h01;
      default: init_byte_c = 8'h06;
    endcase
  end

  // Next-state and output logic; the shared timer counts down and is reloaded on every state entry
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    ready_d     = 1'b0;
    e_d         = e_q;
    rs_d        = rs_q;
    data_d      = data_q;
    if (!tmr_zero_c) tmr_d = tmr_q - TW'(1);

    unique case (state_q)
      PWR_WAIT: if (tmr_zero_c) state_d = INIT_LOAD;
      INIT_LOAD: begin
        rs_d    = 1'b0;
        data_d  = init_byte_c;
        state_d = SETUP;
        tmr_d   = TW'(SU_CYC - 1);
      end
      SETUP: if (tmr_zero_c) begin
        state_d = E_HIGH;
        tmr_d   = TW'(E_CYC - 1);
        e_d     = 1'b1;
      end
      E_HIGH: if (tmr_zero_c) begin
        state_d = HOLD;
        tmr_d   = TW'(HD_CYC - 1);
        e_d     = 1'b0;
      end
      HOLD: if (tmr_zero_c) begin
        state_d = EXEC;
        tmr_d   = is_clr_c ? TW'(CLR_CYC - 1) : TW'(EXEC_CYC - 1);
      end
      EXEC: if (tmr_zero_c) begin
        if (!init_done_q) begin
          if (init_idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = INIT_LOAD;
          end
        end
`ifdef LCD_LINE_WRAP_EN
        else if (pend_q) begin
          rs_d    = 1'b0;
          data_d  = line_q ? 8'hC0 : 8'h80;
          state_d = SETUP;
          tmr_d   = TW'(SU_CYC - 1);
        end
`endif
        else begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        ready_d = init_done_q;
        if (req_valid_i && ready_q) begin
          rs_d    = req_rs_i;
          data_d  = req_data_i;
          state_d = SETUP;
          tmr_d   = TW'(SU_CYC - 1);
          ready_d = 1'b0;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PWR_WAIT;
      tmr_q       <= TW'(PWR_CYC - 1);
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      rw_q        <= 1'b0;
      on_q        <= 1'b1;
      blon_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

`ifdef LCD_LINE_WRAP_EN
  // Cursor tracker follows every byte latched onto the bus except the inserted address commands
  assign load_c = (state_q == INIT_LOAD) || ((state_q == IDLE) && req_valid_i && ready_q);
  assign ins_c  = (state_q == EXEC) && tmr_zero_c && init_done_q && pend_q;

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    pend_d = pend_q;
    if (ins_c) pend_d = 1'b0;
    if (load_c) begin
      if (rs_d) begin
        col_d = col_q + 4'd1;
        if (col_q == 4'd15) begin
          line_d = ~line_q;
          pend_d = 1'b1;
        end
      end else if ((data_d == 8'h01) || (data_d == 8'h02)) begin
        col_d  = 4'd0;
        line_d = 1'b0;
      end else if (data_d[7]) begin
        col_d  = data_d[3:0];
        line_d = data_d[6];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q  <= 4'd0;
      line_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
      pend_q <= pend_d;
    end
  end
`endif

  assign req_ready_o = ready_q;
  assign init_done_o = init_done_q;
  assign lcd_e       = e_q;
  assign lcd_rs      = rs_q;
  assign lcd_rw      = rw_q;
  assign lcd_on      = on_q;
  assign lcd_blon    = blon_q;
  assign data_lcd    = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: reset, init list, table vectors, busy handshake, random traffic.
`timescale 1ns/1ps
module tb_lcd_ctrl;
  localparam int unsigned PWR = 20, SU = 2, E = 4, HD = 2, EX = 10, CLR = 30;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_rs_i = 1'b0;
  logic [7:0] req_data_i = 8'h00;
  logic       req_ready_o, init_done_o, lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon;
  logic [7:0] data_lcd;

  lcd_ctrl #(.PWR_CYC(PWR), .SU_CYC(SU), .E_CYC(E), .HD_CYC(HD), .EXEC_CYC(EX), .CLR_CYC(CLR)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_rs_i(req_rs_i),
    .req_data_i(req_data_i), .req_ready_o(req_ready_o), .init_done_o(init_done_o),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_on(lcd_on), .lcd_blon(lcd_blon),
    .data_lcd(data_lcd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Pulse log: every rising edge of lcd_e with the bus contents at that moment
  typedef struct {logic rs; logic [7:0] d; int t;} pulse_t;
  pulse_t     pq[$];
  logic       e_prev = 1'b0;
  int         rise_t = 0;
  int         rise_bus = 0;
  bit         mid_rst = 1'b0;

  always @(negedge clk) begin
    if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
      pq.push_back('{lcd_rs, data_lcd, cyc});
      rise_t   = cyc;
      rise_bus = int'({lcd_rs, data_lcd});
    end
    if (lcd_e === 1'b0 && e_prev === 1'b1 && !mid_rst) begin
      chk("e_width", cyc - rise_t, E);
      chk("bus_stable", int'({lcd_rs, data_lcd}), rise_bus);
    end
    e_prev = lcd_e;
  end

  // Reference model: execution wait per byte and cursor tracking for the wrap build
  int m_col = 0, m_line = 0;
  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? int'(CLR) : int'(EX);
  endfunction

  task automatic model_step(input logic rs, input logic [7:0] d,
                            output int lat, output int n_ins, output logic [7:0] ib);
    lat   = SU + E + HD + wait_of(rs, d) + 1;
    n_ins = 0;
    ib    = 8'h00;
`ifdef LCD_LINE_WRAP_EN
    if (rs) begin
      m_col++;
      if (m_col == 16) begin
        m_col  = 0;
        m_line = 1 - m_line;
        n_ins  = 1;
        ib     = (m_line == 1) ? 8'hC0 : 8'h80;
        lat   += SU + E + HD + EX;
      end
    end else if (d == 8'h01 || d == 8'h02) begin
      m_col = 0; m_line = 0;
    end else if (d[7]) begin
      m_line = int'(d[6]); m_col = int'(d[3:0]);
    end
`endif
  endtask

  task automatic wait_ready(input int bound, output int t);
    t = -1;
    if (req_ready_o === 1'b1) t = cyc;
    for (int i = 0; i < bound && t < 0; i++) begin
      @(negedge clk);
      if (req_ready_o === 1'b1) t = cyc;
    end
  endtask

  task automatic check_init(input int rel);
    logic [7:0] ib [4];
    int t_done, exp_t, last_t;
    ib[0] = 8'h38; ib[1] = 8'h0C; ib[2] = 8'h01; ib[3] = 8'h06;
    t_done = -1;
    for (int i = 0; i < 400 && t_done < 0; i++) begin
      @(negedge clk);
      if (init_done_o === 1'b1) t_done = cyc;
    end
    chk("init_done_seen", int'(t_done >= 0), 1);
    chk("init_ready_lag", int'(req_ready_o), 0);
    chk("init_pulse_cnt", pq.size(), 4);
    exp_t  = rel + PWR + SU;
    last_t = exp_t;
    for (int k = 0; k < 4 && k < pq.size(); k++) begin
      chk("init_byte", int'(pq[k].d), int'(ib[k]));
      chk("init_rs", int'(pq[k].rs), 0);
      chk("init_rise_t", pq[k].t, exp_t);
      last_t = exp_t;
      exp_t += E + HD + wait_of(1'b0, ib[k]) + 1 + SU;
    end
    chk("init_done_t", t_done, last_t + E + HD + EX);
    @(negedge clk);
    chk("init_ready", int'(req_ready_o), 1);
  endtask

  task automatic do_req(input logic rs, input logic [7:0] d, input int gap, input int exp_lat);
    int acc, t_rdy, lat, n_ins;
    logic [7:0] ins_b;
    wait_ready(300, t_rdy);
    if (t_rdy < 0) chk("pre_ready_timeout", 0, 1);
    repeat (gap) @(negedge clk);
    pq.delete();
    req_rs_i = rs; req_data_i = d; req_valid_i = 1'b1;
    @(negedge clk);
    acc = cyc;
    req_valid_i = 1'b0;
    chk("ready_drop", int'(req_ready_o), 0);
    chk("cap_rs", int'(lcd_rs), int'(rs));
    chk("cap_data", int'(data_lcd), int'(d));
    model_step(rs, d, lat, n_ins, ins_b);
    if (exp_lat >= 0) lat = exp_lat;
    wait_ready(400, t_rdy);
    chk("ready_lat", t_rdy - acc, lat);
    chk("pulse_cnt", pq.size(), 1 + n_ins);
    if (pq.size() > 0) begin
      chk("pulse_t", pq[0].t - acc, SU);
      chk("pulse_rs", int'(pq[0].rs), int'(rs));
      chk("pulse_data", int'(pq[0].d), int'(d));
    end
    if (n_ins > 0 && pq.size() > 1) begin
      chk("ins_rs", int'(pq[1].rs), 0);
      chk("ins_data", int'(pq[1].d), int'(ins_b));
      chk("ins_t", pq[1].t - acc, SU + E + HD + wait_of(rs, d) + SU);
    end
  endtask

  typedef struct {logic rs; logic [7:0] d; int gap; int lat;} vec_t;
  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, acc, acc2, t_rdy, lat, n_ins, t_e;
    logic [7:0] ib, rd;
    logic rr;

    tbl[0] = '{1'b1, 8'h41, 0, 19};
    tbl[1] = '{1'b0, 8'h01, 1, 39};
    tbl[2] = '{1'b1, 8'h42, 3, 19};
    tbl[3] = '{1'b0, 8'h02, 0, 39};
    tbl[4] = '{1'b0, 8'hC0, 2, 19};
    tbl[5] = '{1'b0, 8'h06, 0, 19};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_e", int'(lcd_e), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_data", int'(data_lcd), 0);
    chk("rst_ready", int'(req_ready_o), 0);
    chk("rst_done", int'(init_done_o), 0);
    chk("rst_on", int'(lcd_on), 1);
    chk("rst_blon", int'(lcd_blon), 1);
    rst_i = 1'b0;
    @(negedge clk);
    rel = cyc;
    pq.delete();
    check_init(rel);

    for (int i = 0; i < 6; i++) do_req(tbl[i].rs, tbl[i].d, tbl[i].gap, tbl[i].lat);

    // Clear command, with the next request held on valid throughout the busy period
    wait_ready(300, t_rdy);
    pq.delete();
    req_rs_i = 1'b0; req_data_i = 8'h01; req_valid_i = 1'b1;
    @(negedge clk);
    acc = cyc;
    chk("clr_cap", int'(data_lcd), 1);
    model_step(1'b0, 8'h01, lat, n_ins, ib);
    req_rs_i = 1'b1; req_data_i = 8'h5A;
    wait_ready(400, t_rdy);
    chk("busy_ready_lat", t_rdy - acc, SU + E + HD + CLR + 1);
    chk("busy_no_accept", pq.size(), 1);
    @(negedge clk);
    acc2 = cyc;
    req_valid_i = 1'b0;
    chk("held_accept_t", acc2 - t_rdy, 1);
    chk("held_ready_drop", int'(req_ready_o), 0);
    chk("held_cap_data", int'(data_lcd), 8'h5A);
    model_step(1'b1, 8'h5A, lat, n_ins, ib);
    wait_ready(400, t_rdy);
    chk("held_ready_lat", t_rdy - acc2, lat);

    // Random traffic against the model
    for (int i = 0; i < 24; i++) begin
      rr = 1'(($urandom_range(0, 1)));
      rd = 8'($urandom);
      if (!rr && $urandom_range(0, 3) == 0) rd = 8'($urandom_range(1, 2));
      do_req(rr, rd, int'($urandom_range(0, 3)), -1);
    end

`ifdef LCD_LINE_WRAP_EN
    do_req(1'b0, 8'h01, 0, -1);
    for (int i = 0; i < 17; i++) do_req(1'b1, 8'(8'h30 + i), 0, -1);
`endif

    // Reset while lcd_e is high
    wait_ready(300, t_rdy);
    req_rs_i = 1'b1; req_data_i = 8'h55; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    t_e = -1;
    for (int i = 0; i < 20 && t_e < 0; i++) begin
      @(negedge clk);
      if (lcd_e === 1'b1) t_e = cyc;
    end
    chk("midrst_e_seen", int'(t_e >= 0), 1);
    mid_rst = 1'b1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_e", int'(lcd_e), 0);
    chk("midrst_done", int'(init_done_o), 0);
    chk("midrst_ready", int'(req_ready_o), 0);
    rst_i = 1'b0;
    @(negedge clk);
    rel = cyc;
    pq.delete();
    mid_rst = 1'b0;
    m_col = 0; m_line = 0;
    check_init(rel);
    do_req(1'b1, 8'h41, 0, 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
